store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit_pkg.sv | 19 +
 rtl/store_align.sv | 56 +++++
 rtl/store_unit.sv | 159 +++++++++++++++
 tb/tb_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared store encodings, beat-state type and size helper for the store unit.
package store_unit_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } beatState_t;

  // Access size in bytes from the low two funct3 bits (1, 2, 4 or 8).
  function automatic logic [3:0] sizeBytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/store_align.sv
// Purely combinational lane alignment: shifts data/strobe by the byte offset and
// splits anything that spills past the word into a second-beat data/strobe pair.
module store_align
  import store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   alignAddr,
  output logic [XLEN-1:0]   data0,
  output logic [XLEN/8-1:0] strb0,
  output logic [XLEN-1:0]   data1,
  output logic [XLEN/8-1:0] strb1,
  output logic              crossing,
  output logic              illegalSize
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [OFFW-1:0]   off;
  logic [3:0]        size;
  logic [4:0]        endByte;
  logic [2*NB-1:0]   sizeMask;
  logic [2*NB-1:0]   wideStrb;
  logic [2*XLEN-1:0] wideData;

  assign off  = addr[OFFW-1:0];
  assign size = sizeBytes(funct3[1:0]);

  always_comb begin
    sizeMask = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      sizeMask[i] = (i < int'(size));
    end
  end

  // Shifting into a double-width window keeps the spill-over bytes for beat 1.
  assign wideStrb = sizeMask << off;
  assign wideData = {{XLEN{1'b0}}, data} << {off, 3'b000};

  assign data0 = wideData[XLEN-1:0];
  assign data1 = wideData[2*XLEN-1:XLEN];
  assign strb0 = wideStrb[NB-1:0];
  assign strb1 = wideStrb[2*NB-1:NB];

  assign endByte   = 5'(off) + 5'(size);
  assign crossing  = endByte > 5'(NB);
  assign alignAddr = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Reserved sizes, and doubleword stores on a 32-bit datapath, are never legal.
  assign illegalSize = funct3[2] | ((funct3 == F3_SD) && (XLEN < 64));

endmodule

// File: rtl/store_unit.sv
// Store buffer: aligned write beats out of a FIFO, min 1-cycle accept-to-beat latency.
// req_ready = !full (no pop bypass); beats hold stable while mem_ready is low.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int DEPTH            = 4,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_data,
  input  logic [2:0]               req_funct3,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  output logic                     fault_valid,
  output logic [XLEN-1:0]          fault_addr,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] alignAddr;
  logic [XLEN-1:0] alignData0;
  logic [XLEN-1:0] alignData1;
  logic [NB-1:0]   alignStrb0;
  logic [NB-1:0]   alignStrb1;
  logic            crossing;
  logic            illegalSize;

  store_align #(
    .XLEN(XLEN)
  ) uAlign (
    .addr       (req_addr),
    .data       (req_data),
    .funct3     (req_funct3),
    .alignAddr  (alignAddr),
    .data0      (alignData0),
    .strb0      (alignStrb0),
    .data1      (alignData1),
    .strb1      (alignStrb1),
    .crossing   (crossing),
    .illegalSize(illegalSize)
  );

  logic [XLEN-1:0] entAddr  [DEPTH];
  logic [XLEN-1:0] entData0 [DEPTH];
  logic [XLEN-1:0] entData1 [DEPTH];
  logic [NB-1:0]   entStrb0 [DEPTH];
  logic [NB-1:0]   entStrb1 [DEPTH];
  logic            entTwo   [DEPTH];

  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [AW:0]     cnt;
  logic            full;
  logic            accept;
  logic            faultCond;
  logic            push;
  logic            pop;
  logic            memFire;
  logic            splitEn;
  beatState_t      beatQ;
  beatState_t      beatD;
  logic            faultValidQ;
  logic [XLEN-1:0] faultAddrQ;

  assign splitEn   = (SPLIT_MISALIGNED != 0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign faultCond = illegalSize || (crossing && !splitEn);
  assign push      = accept && !faultCond;

  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign mem_valid = !empty;
  assign memFire   = mem_valid && mem_ready;

  // Entry payload needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      entAddr[wrPtr]  <= alignAddr;
      entData0[wrPtr] <= alignData0;
      entStrb0[wrPtr] <= alignStrb0;
      entData1[wrPtr] <= alignData1;
      entStrb1[wrPtr] <= alignStrb1;
      entTwo[wrPtr]   <= crossing;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) beatQ <= BEAT0;
    else          beatQ <= beatD;
  end

  // The head entry is released only after its last beat is accepted.
  always_comb begin
    beatD = beatQ;
    pop   = 1'b0;
    case (beatQ)
      BEAT0: begin
        if (memFire) begin
          if (entTwo[rdPtr]) beatD = BEAT1;
          else               pop   = 1'b1;
        end
      end
      BEAT1: begin
        if (memFire) begin
          beatD = BEAT0;
          pop   = 1'b1;
        end
      end
      default: beatD = BEAT0;
    endcase
  end

  assign mem_addr  = (beatQ == BEAT1) ? entAddr[rdPtr] + XLEN'(NB) : entAddr[rdPtr];
  assign mem_wdata = (beatQ == BEAT1) ? entData1[rdPtr] : entData0[rdPtr];
  assign mem_wstrb = (beatQ == BEAT1) ? entStrb1[rdPtr] : entStrb0[rdPtr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      faultValidQ <= 1'b0;
      faultAddrQ  <= '0;
    end else begin
      faultValidQ <= accept && faultCond;
      if (accept && faultCond) faultAddrQ <= req_addr;
    end
  end

  assign fault_valid = faultValidQ;
  assign fault_addr  = faultAddrQ;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench: split (A) and faulting (B) 32-bit units plus a 64-bit unit (C).
module tb_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        aReqValid, aReqReady, aMemValid, aMemReady, aFaultValid, aEmpty;
  logic [31:0] aReqAddr, aReqData, aMemAddr, aMemWdata, aFaultAddr;
  logic [2:0]  aReqFunct3, aCount;
  logic [3:0]  aMemWstrb;

  logic        bReqValid, bReqReady, bMemValid, bMemReady, bFaultValid, bEmpty;
  logic [31:0] bReqAddr, bReqData, bMemAddr, bMemWdata, bFaultAddr;
  logic [2:0]  bReqFunct3, bCount;
  logic [3:0]  bMemWstrb;

  logic        cReqValid, cReqReady, cMemValid, cMemReady, cFaultValid, cEmpty;
  logic [63:0] cReqAddr, cReqData, cMemAddr, cMemWdata, cFaultAddr;
  logic [2:0]  cReqFunct3, cCount;
  logic [7:0]  cMemWstrb;

  store_unit #(.XLEN(32), .DEPTH(4), .SPLIT_MISALIGNED(1)) dutA (
    .clk(clk), .reset_n(reset_n), .req_valid(aReqValid), .req_ready(aReqReady),
    .req_addr(aReqAddr), .req_data(aReqData), .req_funct3(aReqFunct3),
    .mem_valid(aMemValid), .mem_ready(aMemReady), .mem_addr(aMemAddr),
    .mem_wdata(aMemWdata), .mem_wstrb(aMemWstrb), .fault_valid(aFaultValid),
    .fault_addr(aFaultAddr), .empty(aEmpty), .count(aCount)
  );

  store_unit #(.XLEN(32), .DEPTH(4), .SPLIT_MISALIGNED(0)) dutB (
    .clk(clk), .reset_n(reset_n), .req_valid(bReqValid), .req_ready(bReqReady),
    .req_addr(bReqAddr), .req_data(bReqData), .req_funct3(bReqFunct3),
    .mem_valid(bMemValid), .mem_ready(bMemReady), .mem_addr(bMemAddr),
    .mem_wdata(bMemWdata), .mem_wstrb(bMemWstrb), .fault_valid(bFaultValid),
    .fault_addr(bFaultAddr), .empty(bEmpty), .count(bCount)
  );

  store_unit #(.XLEN(64), .DEPTH(4), .SPLIT_MISALIGNED(1)) dutC (
    .clk(clk), .reset_n(reset_n), .req_valid(cReqValid), .req_ready(cReqReady),
    .req_addr(cReqAddr), .req_data(cReqData), .req_funct3(cReqFunct3),
    .mem_valid(cMemValid), .mem_ready(cMemReady), .mem_addr(cMemAddr),
    .mem_wdata(cMemWdata), .mem_wstrb(cMemWstrb), .fault_valid(cFaultValid),
    .fault_addr(cFaultAddr), .empty(cEmpty), .count(cCount)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        fault;
    logic        two;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs [10];

  task automatic runVec(input vec_t v, input int idx);
    @(negedge clk);
    aReqValid = 1'b1; aReqAddr = v.addr; aReqData = v.data; aReqFunct3 = v.f3; aMemReady = 1'b0;
    @(negedge clk);
    aReqValid = 1'b0;
    if (v.fault) begin
      check($sformatf("v%0d fault_valid", idx), 64'(aFaultValid), 64'h1);
      check($sformatf("v%0d fault_addr", idx), 64'(aFaultAddr), 64'(v.addr));
      check($sformatf("v%0d empty", idx), 64'(aEmpty), 64'h1);
      @(negedge clk);
      check($sformatf("v%0d fault pulse", idx), 64'(aFaultValid), 64'h0);
    end else begin
      check($sformatf("v%0d mem_valid", idx), 64'(aMemValid), 64'h1);
      check($sformatf("v%0d addr0", idx), 64'(aMemAddr), 64'(v.a0));
      check($sformatf("v%0d data0", idx), 64'(aMemWdata), 64'(v.d0));
      check($sformatf("v%0d strb0", idx), 64'(aMemWstrb), 64'(v.s0));
      aMemReady = 1'b1;
      @(negedge clk);
      if (v.two) begin
        check($sformatf("v%0d count mid", idx), 64'(aCount), 64'h1);
        check($sformatf("v%0d addr1", idx), 64'(aMemAddr), 64'(v.a1));
        check($sformatf("v%0d data1", idx), 64'(aMemWdata), 64'(v.d1));
        check($sformatf("v%0d strb1", idx), 64'(aMemWstrb), 64'(v.s1));
        @(negedge clk);
      end
      aMemReady = 1'b0;
      check($sformatf("v%0d drained", idx), 64'(aEmpty), 64'h1);
    end
  endtask

  initial begin
    vecs[0] = '{32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{32'h103, 32'h0000ABCD, 3'b001, 1'b0, 1'b1, 32'h100, 32'hCD000000, 4'h8, 32'h104, 32'h000000AB, 4'h1};
    vecs[2] = '{32'h201, 32'h0000005A, 3'b000, 1'b0, 1'b0, 32'h200, 32'h00005A00, 4'h2, 32'h0, 32'h0, 4'h0};
    vecs[3] = '{32'h202, 32'h00001234, 3'b001, 1'b0, 1'b0, 32'h200, 32'h12340000, 4'hC, 32'h0, 32'h0, 4'h0};
    vecs[4] = '{32'h302, 32'h11223344, 3'b010, 1'b0, 1'b1, 32'h300, 32'h33440000, 4'hC, 32'h304, 32'h00001122, 4'h3};
    vecs[5] = '{32'h401, 32'hA1B2C3D4, 3'b010, 1'b0, 1'b1, 32'h400, 32'hB2C3D400, 4'hE, 32'h404, 32'h000000A1, 4'h1};
    vecs[6] = '{32'h503, 32'h000000EE, 3'b000, 1'b0, 1'b0, 32'h500, 32'hEE000000, 4'h8, 32'h0, 32'h0, 4'h0};
    vecs[7] = '{32'h600, 32'h00000001, 3'b100, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[8] = '{32'h700, 32'h00000001, 3'b011, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0};
    vecs[9] = '{32'h001, 32'h00007788, 3'b001, 1'b0, 1'b0, 32'h000, 32'h00778800, 4'h6, 32'h0, 32'h0, 4'h0};

    reset_n = 1'b0;
    aReqValid = 1'b0; aReqAddr = '0; aReqData = '0; aReqFunct3 = '0; aMemReady = 1'b0;
    bReqValid = 1'b0; bReqAddr = '0; bReqData = '0; bReqFunct3 = '0; bMemReady = 1'b1;
    cReqValid = 1'b0; cReqAddr = '0; cReqData = '0; cReqFunct3 = '0; cMemReady = 1'b0;
    #1;
    check("rst mem_valid", 64'(aMemValid), 64'h0);
    check("rst fault_valid", 64'(aFaultValid), 64'h0);
    check("rst fault_addr", 64'(aFaultAddr), 64'h0);
    check("rst empty", 64'(aEmpty), 64'h1);
    check("rst count", 64'(aCount), 64'h0);
    check("rst req_ready", 64'(aReqReady), 64'h1);
    check("rst C mem_valid", 64'(cMemValid), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) runVec(vecs[i], i);

    // SPLIT_MISALIGNED=0: crossing halfword is dropped and faulted.
    @(negedge clk);
    bReqValid = 1'b1; bReqAddr = 32'h103; bReqData = 32'hABCD; bReqFunct3 = 3'b001;
    @(negedge clk);
    bReqValid = 1'b0;
    check("B fault_valid", 64'(bFaultValid), 64'h1);
    check("B fault_addr", 64'(bFaultAddr), 64'h103);
    check("B empty", 64'(bEmpty), 64'h1);
    check("B mem_valid", 64'(bMemValid), 64'h0);
    @(negedge clk);
    check("B fault pulse", 64'(bFaultValid), 64'h0);
    check("B fault_addr held", 64'(bFaultAddr), 64'h103);
    check("B empty after", 64'(bEmpty), 64'h1);

    // Fill to DEPTH with mem stalled, then pop one and let the fifth in.
    @(negedge clk);
    aMemReady = 1'b0; aReqValid = 1'b1; aReqFunct3 = 3'b000; aReqAddr = 32'h10; aReqData = 32'h0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      aReqAddr = 32'((i + 1) * 16); aReqData = 32'(i);
    end
    check("full count", 64'(aCount), 64'h4);
    check("full req_ready", 64'(aReqReady), 64'h0);
    @(negedge clk);
    check("full hold count", 64'(aCount), 64'h4);
    check("full head addr", 64'(aMemAddr), 64'h10);
    aMemReady = 1'b1;
    @(negedge clk);
    aMemReady = 1'b0;
    check("pop count", 64'(aCount), 64'h3);
    check("pop req_ready", 64'(aReqReady), 64'h1);
    @(negedge clk);
    aReqValid = 1'b0;
    check("refill count", 64'(aCount), 64'h4);
    aMemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("order %0d valid", k), 64'(aMemValid), 64'h1);
      check($sformatf("order %0d addr", k), 64'(aMemAddr), 64'((k + 2) * 16));
      @(negedge clk);
    end
    aMemReady = 1'b0;
    check("order drained", 64'(aEmpty), 64'h1);

    // Simultaneous push and pop keeps count steady.
    aReqValid = 1'b1; aReqAddr = 32'h80;
    @(negedge clk);
    aMemReady = 1'b1; aReqAddr = 32'h90;
    @(negedge clk);
    check("pushpop count 1", 64'(aCount), 64'h1);
    check("pushpop addr 1", 64'(aMemAddr), 64'h90);
    aReqAddr = 32'hA0;
    @(negedge clk);
    aReqValid = 1'b0;
    check("pushpop count 2", 64'(aCount), 64'h1);
    check("pushpop addr 2", 64'(aMemAddr), 64'hA0);
    @(negedge clk);
    aMemReady = 1'b0;
    check("pushpop drained", 64'(aCount), 64'h0);

    // Reset while beat 1 of a split store is pending.
    aReqValid = 1'b1; aReqAddr = 32'h103; aReqData = 32'hABCD; aReqFunct3 = 3'b001;
    @(negedge clk);
    aReqValid = 1'b0; aMemReady = 1'b1;
    @(negedge clk);
    aMemReady = 1'b0;
    check("split beat1 pending", 64'(aMemAddr), 64'h104);
    reset_n = 1'b0;
    #1;
    check("mid-rst mem_valid", 64'(aMemValid), 64'h0);
    check("mid-rst count", 64'(aCount), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-rst idle", 64'(aMemValid), 64'h0);
    aReqValid = 1'b1; aReqAddr = 32'h200; aReqData = 32'hCAFEF00D; aReqFunct3 = 3'b010;
    @(negedge clk);
    aReqValid = 1'b0;
    check("post-rst addr", 64'(aMemAddr), 64'h200);
    check("post-rst data", 64'(aMemWdata), 64'hCAFEF00D);
    check("post-rst strb", 64'(aMemWstrb), 64'hF);
    aMemReady = 1'b1;
    @(negedge clk);
    aMemReady = 1'b0;
    check("post-rst drained", 64'(aEmpty), 64'h1);

    // 64-bit unit: doubleword, upper-half word, reserved funct3.
    cReqValid = 1'b1; cReqAddr = 64'h8; cReqData = 64'h0123456789ABCDEF; cReqFunct3 = 3'b011;
    @(negedge clk);
    cReqValid = 1'b0;
    check("C sd addr", cMemAddr, 64'h8);
    check("C sd data", cMemWdata, 64'h0123456789ABCDEF);
    check("C sd strb", 64'(cMemWstrb), 64'hFF);
    cMemReady = 1'b1;
    @(negedge clk);
    cMemReady = 1'b0;
    check("C sd drained", 64'(cEmpty), 64'h1);
    cReqValid = 1'b1; cReqAddr = 64'h4; cReqData = 64'hCAFEBABE; cReqFunct3 = 3'b010;
    @(negedge clk);
    cReqValid = 1'b0;
    check("C sw addr", cMemAddr, 64'h0);
    check("C sw data", cMemWdata, 64'hCAFEBABE00000000);
    check("C sw strb", 64'(cMemWstrb), 64'hF0);
    cMemReady = 1'b1;
    @(negedge clk);
    cMemReady = 1'b0;
    cReqValid = 1'b1; cReqAddr = 64'h18; cReqData = 64'h1; cReqFunct3 = 3'b111;
    @(negedge clk);
    cReqValid = 1'b0;
    check("C f3=111 fault", 64'(cFaultValid), 64'h1);
    check("C f3=111 addr", cFaultAddr, 64'h18);
    check("C f3=111 no beat", 64'(cMemValid), 64'h0);
    check("C f3=111 empty", 64'(cEmpty), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
